mips_cpu_harvard: RTL and testbench
===================================

Name: mips_cpu_harvard

Overview:
- Single-cycle MIPS-I subset CPU with separate instruction and data ports (Harvard).
- Instruction fetch is combinational from an external ROM. Data accesses go to the companion block data_memory.
- `register_v0` exposes `$2` for bench checking.
- The CPU halts (`active`=0) when execution reaches address 0x00000000.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value after reset and at power-up.
- HALT_ADDR, 32'h00000000, PC value that stops execution.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- active  out  1  high while executing; low once PC==HALT_ADDR.
- register_v0  out  32  live value of `$2`.
- clk_enable  in  1  when 0, no architectural state changes.
- instr_address  out  32  current PC.
- instr_readdata  in  32  instruction at `instr_address`, combinational, same cycle.
- data_address  out  32  byte address for load/store (rs + sign-extended imm).
- data_write  out  1  store strobe.
- data_read  out  1  load strobe.
- data_writedata  out  32  store data (rt).
- data_readdata  in  32  load data, combinational, same cycle.

Behaviour:
- Reset: asynchronous, active-high (fixed).
  - Outputs on reset: PC=RESET_VECTOR, `active`=1, `register_v0`=0.
  - All 32 GPRs clear to 0; the pending-branch state is cleared.
- Power-up: same values as reset, so the CPU runs from RESET_VECTOR even if `reset` is never asserted.
- Timing: one instruction per enabled cycle. Register write, PC update and data-memory write all occur on posedge `clk` when `clk_enable`=1.
- `$0` reads 0; writes to `$0` are discarded.
- Branch delay slot: the instruction after any taken jump or branch always executes; the target is applied after it.
  - Delay-slot reads observe writes made by the jump itself (e.g. JAL's `$31`).
- Supported instructions:
  - R-type: ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, SLLV, SRLV, SRAV, JR, JALR.
  - I-type: ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI, LW, SW, BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ.
  - J-type: J, JAL.
- Arithmetic and immediate rules:
  - All arithmetic is 32-bit modulo; no overflow traps.
  - ANDI, ORI and XORI zero-extend the immediate; all others sign-extend.
- Jump and branch targets:
  - J/JAL target = {(PC+4)[31:28], instr_index, 2'b00}.
  - Branch target = PC+4 + (sext(imm)<<2).
  - JR/JALR target = rs.
- Links: JAL writes PC+8 to `$31`; JALR writes PC+8 to rd.
- Any unsupported opcode executes as a NOP.
- Memory access:
  - LW/SW are word-aligned; `data_address` = rs + sext(imm).
  - `data_read` and `data_write` are asserted combinationally only during LW/SW.
- Halt:
  - When PC reaches HALT_ADDR (normally via `jr $0`), `active` goes 0 in the same cycle and PC holds.
  - While halted, no register or memory writes occur and `data_write`/`data_read` stay 0.
  - Only `reset` leaves the halted state.
- Clock enable: `clk_enable`=0 freezes PC, GPRs and delay-slot state, and suppresses `data_write`.
- Reset mid-delay-slot discards the pending target.

Decomposition:
- Package mips_pkg:
  - opcode and funct constants;
  - RESET_VECTOR and HALT_ADDR;
  - ALU-op enum.
- Sub-module mips_register_file:
  - 32x32 registers, 2 async read ports, 1 sync write port;
  - `$0` hardwired to 0;
  - dedicated `$2` output.
- Companion block data_memory, ports (`clk`, `clk_enable`, `data_address`, `data_writedata`, `data_write`, `data_read`, `reset`, `data_readdata`):
  - 1024 words indexed by `data_address[11:2]`;
  - combinational read when `data_read` is high, else 0;
  - write on posedge when `data_write && clk_enable`;
  - contents cleared on reset.

Test Plan:
- JAL/delay-slot program, one instruction per word from 0xBFC00000: `jal 0xBFC0000C`; `addiu $1,$31,0`; `addiu $2,$2,1` (skipped); `jal 0xBFC00018`; `addiu $2,$2,32`; `addiu $2,$2,1` (skipped); `subu $3,$31,$1`; `addu $2,$2,$3`; `jr $0`; `addiu $0,$0,0`.
  -> when `instr_address`==0: `register_v0`==44 and `active`==0.
- ALU: `lui $2,0x8000`; `sra $2,$2,4` -> `register_v0`==0xF8000000; `sltiu $2,$0,1` -> 1.
- Memory: `addiu $4,$0,0x55`; `sw $4,8($0)`; `lw $2,8($0)` -> `register_v0`==0x55, `data_write` high for exactly 1 cycle.
- Branches: `beq $0,$0,+2` with `addiu $2,$0,7` in the delay slot and `addiu $2,$2,1` at the skipped slot -> `register_v0`==7; untaken `bne $0,$0` falls through.
- Freeze: hold `clk_enable`=0 for 5 cycles mid-program -> `instr_address` and `register_v0` unchanged; final result identical.
- Reset: assert `reset` mid-run between edges -> `instr_address` becomes 0xBFC00000 immediately, `register_v0`==0, `active`==1.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants, decode enums and ALU helper for the MIPS-I subset core
// No ports: opcode/funct encodings, reset/halt addresses, ALU and write-back selectors.
package mips_pkg;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC00000;
  localparam logic [31:0] DEFAULT_HALT_ADDR    = 32'h00000000;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL funct codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // REGIMM rt selectors
  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_t;

  typedef enum logic [1:0] {
    WB_ALU, WB_MEM, WB_LINK
  } wb_sel_t;

  // Shifts operate on b (rt) by sh; LUI places b[15:0] in the upper half.
  function automatic logic [31:0] alu_compute(input alu_op_t op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] r;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_NOR:  r = ~(a | b);
      ALU_SLT:  r = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: r = {31'd0, a < b};
      ALU_SLL:  r = b << sh;
      ALU_SRL:  r = b >> sh;
      ALU_SRA:  r = $unsigned($signed(b) >>> sh);
      ALU_LUI:  r = {b[15:0], 16'd0};
      default:  r = a + b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_memory.sv
// rtl/data_memory.sv - 1024-word data RAM companion for the Harvard core
// Ports: clk, clk_enable, reset (async, active-high, clears contents), data_address (byte address,
//        word index [11:2]), data_writedata, data_write, data_read, data_readdata (0 unless reading).
module data_memory (
  input  logic        clk,
  input  logic        clk_enable,
  input  logic        reset,
  input  logic [31:0] data_address,
  input  logic [31:0] data_writedata,
  input  logic        data_write,
  input  logic        data_read,
  output logic [31:0] data_readdata
);

  logic [31:0] mem [0:1023];
  logic [9:0]  word_index;
  logic        unused_addr_bits;

  assign word_index       = data_address[11:2];
  assign unused_addr_bits = ^{data_address[31:12], data_address[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else if (data_write && clk_enable) begin
      mem[word_index] <= data_writedata;
    end
  end

  assign data_readdata = data_read ? mem[word_index] : 32'd0;

endmodule

// File: rtl/mips_register_file.sv
// rtl/mips_register_file.sv - 32x32 GPR file, two async read ports, one sync write port
// Ports: clk, reset (async, active-high, clears all registers), write_enable/write_addr/write_data,
//        read_addr_a/read_data_a, read_addr_b/read_data_b, register_v0 (live $2).
module mips_register_file import mips_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_enable,
  input  logic [4:0]  write_addr,
  input  logic [31:0] write_data,
  input  logic [4:0]  read_addr_a,
  output logic [31:0] read_data_a,
  input  logic [4:0]  read_addr_b,
  output logic [31:0] read_data_b,
  output logic [31:0] register_v0
);

  logic [31:0] regs [0:31];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (write_enable && (write_addr != 5'd0)) begin
      regs[write_addr] <= write_data;
    end
  end

  // $0 is never written, but force the read anyway so it cannot depend on reset history.
  assign read_data_a = (read_addr_a == 5'd0) ? 32'd0 : regs[read_addr_a];
  assign read_data_b = (read_addr_b == 5'd0) ? 32'd0 : regs[read_addr_b];
  assign register_v0 = regs[2];

endmodule

// File: rtl/mips_cpu_harvard.sv
// rtl/mips_cpu_harvard.sv - single-cycle MIPS-I subset CPU with split instruction/data ports
// Ports: clk, reset (async, active-high), clk_enable (0 freezes all state), active (0 once PC==HALT_ADDR),
//        register_v0 ($2), instr_address/instr_readdata (combinational fetch),
//        data_address/data_write/data_read/data_writedata/data_readdata (combinational data access).
module mips_cpu_harvard import mips_pkg::*; #(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = DEFAULT_HALT_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  input  logic        clk_enable,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  // The PC is stored XOR'd with RESET_VECTOR so an all-zero register (reset or power-up)
  // decodes to RESET_VECTOR without needing initial values.
  logic [31:0] pc_q;
  logic        pending_q;
  logic [31:0] target_q;
  logic [31:0] pc;
  logic        commit;

  assign pc            = pc_q ^ RESET_VECTOR;
  assign instr_address = pc;
  assign active        = (pc != HALT_ADDR);
  assign commit        = clk_enable && active;

  // Instruction fields
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm_sext, imm_zext;

  assign op       = instr_readdata[31:26];
  assign rs       = instr_readdata[25:21];
  assign rt       = instr_readdata[20:16];
  assign rd       = instr_readdata[15:11];
  assign shamt    = instr_readdata[10:6];
  assign funct    = instr_readdata[5:0];
  assign imm_sext = {{16{instr_readdata[15]}}, instr_readdata[15:0]};
  assign imm_zext = {16'd0, instr_readdata[15:0]};

  logic [31:0] rs_val, rt_val;
  logic [31:0] pc_plus4, pc_plus8, branch_target, jump_target;

  assign pc_plus4      = pc + 32'd4;
  assign pc_plus8      = pc + 32'd8;
  assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};
  assign jump_target   = {pc_plus4[31:28], instr_readdata[25:0], 2'b00};

  // Decode
  alu_op_t     alu_op;
  wb_sel_t     wb_sel;
  logic [31:0] alu_b;
  logic [4:0]  shift_amt;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic        is_load, is_store;
  logic        take;
  logic [31:0] take_target;

  always_comb begin
    alu_op      = ALU_ADD;
    wb_sel      = WB_ALU;
    alu_b       = rt_val;
    shift_amt   = shamt;
    rf_we       = 1'b0;
    rf_waddr    = rd;
    is_load     = 1'b0;
    is_store    = 1'b0;
    take        = 1'b0;
    take_target = branch_target;
    case (op)
      OP_SPECIAL: begin
        rf_we = 1'b1;
        case (funct)
          FN_SLL:  alu_op = ALU_SLL;
          FN_SRL:  alu_op = ALU_SRL;
          FN_SRA:  alu_op = ALU_SRA;
          FN_SLLV: begin alu_op = ALU_SLL; shift_amt = rs_val[4:0]; end
          FN_SRLV: begin alu_op = ALU_SRL; shift_amt = rs_val[4:0]; end
          FN_SRAV: begin alu_op = ALU_SRA; shift_amt = rs_val[4:0]; end
          FN_ADDU: alu_op = ALU_ADD;
          FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLTU: alu_op = ALU_SLTU;
          FN_JR:   begin rf_we = 1'b0; take = 1'b1; take_target = rs_val; end
          FN_JALR: begin take = 1'b1; take_target = rs_val; wb_sel = WB_LINK; end
          default: rf_we = 1'b0;
        endcase
      end
      OP_REGIMM: begin
        if (rt == RT_BLTZ) take = rs_val[31];
        else if (rt == RT_BGEZ) take = !rs_val[31];
      end
      OP_J:    begin take = 1'b1; take_target = jump_target; end
      OP_JAL:  begin
        take = 1'b1; take_target = jump_target;
        rf_we = 1'b1; rf_waddr = 5'd31; wb_sel = WB_LINK;
      end
      OP_BEQ:  take = (rs_val == rt_val);
      OP_BNE:  take = (rs_val != rt_val);
      OP_BLEZ: take = rs_val[31] || (rs_val == 32'd0);
      OP_BGTZ: take = !rs_val[31] && (rs_val != 32'd0);
      OP_ADDIU: begin alu_b = imm_sext; rf_we = 1'b1; rf_waddr = rt; end
      OP_SLTI:  begin alu_op = ALU_SLT;  alu_b = imm_sext; rf_we = 1'b1; rf_waddr = rt; end
      OP_SLTIU: begin alu_op = ALU_SLTU; alu_b = imm_sext; rf_we = 1'b1; rf_waddr = rt; end
      OP_ANDI:  begin alu_op = ALU_AND;  alu_b = imm_zext; rf_we = 1'b1; rf_waddr = rt; end
      OP_ORI:   begin alu_op = ALU_OR;   alu_b = imm_zext; rf_we = 1'b1; rf_waddr = rt; end
      OP_XORI:  begin alu_op = ALU_XOR;  alu_b = imm_zext; rf_we = 1'b1; rf_waddr = rt; end
      OP_LUI:   begin alu_op = ALU_LUI;  alu_b = imm_zext; rf_we = 1'b1; rf_waddr = rt; end
      OP_LW:    begin rf_we = 1'b1; rf_waddr = rt; wb_sel = WB_MEM; is_load = 1'b1; end
      OP_SW:    is_store = 1'b1;
      default:  ;
    endcase
  end

  logic [31:0] alu_result, wb_data;

  assign alu_result = alu_compute(alu_op, rs_val, alu_b, shift_amt);

  always_comb begin
    case (wb_sel)
      WB_MEM:  wb_data = data_readdata;
      WB_LINK: wb_data = pc_plus8;
      default: wb_data = alu_result;
    endcase
  end

  mips_register_file u_regs (
    .clk          (clk),
    .reset        (reset),
    .write_enable (rf_we && commit),
    .write_addr   (rf_waddr),
    .write_data   (wb_data),
    .read_addr_a  (rs),
    .read_data_a  (rs_val),
    .read_addr_b  (rt),
    .read_data_b  (rt_val),
    .register_v0  (register_v0)
  );

  assign data_address   = rs_val + imm_sext;
  assign data_writedata = rt_val;
  assign data_read      = is_load && active;
  assign data_write     = is_store && commit;

  // A taken jump/branch only arms the target; the delay-slot instruction runs first,
  // then the armed target replaces PC+4 on the following commit.
  logic [31:0] next_pc;
  assign next_pc = pending_q ? target_q : pc_plus4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= '0;
      pending_q <= 1'b0;
      target_q  <= '0;
    end else if (commit) begin
      pc_q      <= next_pc ^ RESET_VECTOR;
      pending_q <= take;
      target_q  <= take_target;
    end
  end

endmodule

// File: tb/tb_mips_cpu_harvard.sv
// tb/tb_mips_cpu_harvard.sv - directed self-checking bench for mips_cpu_harvard with data_memory
module tb_mips_cpu_harvard;

  logic        clk;
  logic        reset;
  logic        active;
  logic [31:0] register_v0;
  logic        clk_enable;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  logic [31:0] rom [0:63];
  int n_assert = 0;
  int n_fail   = 0;
  int dw_count = 0;

  localparam logic [31:0] BASE = 32'hBFC00000;

  mips_cpu_harvard dut (
    .clk            (clk),
    .reset          (reset),
    .active         (active),
    .register_v0    (register_v0),
    .clk_enable     (clk_enable),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .data_address   (data_address),
    .data_write     (data_write),
    .data_read      (data_read),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata)
  );

  data_memory mem (
    .clk            (clk),
    .clk_enable     (clk_enable),
    .reset          (reset),
    .data_address   (data_address),
    .data_writedata (data_writedata),
    .data_write     (data_write),
    .data_read      (data_read),
    .data_readdata  (data_readdata)
  );

  assign instr_readdata = (instr_address[31:8] == 24'hBFC000) ? rom[instr_address[7:2]] : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (data_write && clk_enable) dw_count++;

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_type(input logic [5:0] op, input logic [31:0] addr);
    return {op, addr[27:2]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic run_to_halt(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (instr_address === 32'h0) break;
      step(1);
    end
    check("halt_pc", instr_address, 32'h0);
  endtask

  task automatic load_jal_prog();
    clear_rom();
    rom[0] = j_type(6'h03, 32'hBFC0000C);        // jal 0xBFC0000C
    rom[1] = i_type(6'h09, 5'd31, 5'd1, 16'd0);  // addiu $1,$31,0
    rom[2] = i_type(6'h09, 5'd2, 5'd2, 16'd1);   // addiu $2,$2,1 (skipped)
    rom[3] = j_type(6'h03, 32'hBFC00018);        // jal 0xBFC00018
    rom[4] = i_type(6'h09, 5'd2, 5'd2, 16'd32);  // addiu $2,$2,32
    rom[5] = i_type(6'h09, 5'd2, 5'd2, 16'd1);   // skipped
    rom[6] = r_type(5'd31, 5'd1, 5'd3, 5'd0, 6'h23); // subu $3,$31,$1
    rom[7] = r_type(5'd2, 5'd3, 5'd2, 5'd0, 6'h21);  // addu $2,$2,$3
    rom[8] = r_type(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);  // jr $0
    rom[9] = i_type(6'h09, 5'd0, 5'd0, 16'd0);   // addiu $0,$0,0
  endtask

  initial begin
    reset      = 1'b1;
    clk_enable = 1'b1;
    clear_rom();

    // JAL / delay slot program with a freeze window
    load_jal_prog();
    do_reset();
    check("rst_pc", instr_address, BASE);
    check("rst_v0", register_v0, 32'd0);
    check("rst_active", {31'd0, active}, 32'd1);
    step(1);
    check("jal_delay_pc", instr_address, BASE + 32'h4);
    step(1);
    check("jal_target_pc", instr_address, BASE + 32'hC);
    step(2);
    check("jal2_target_pc", instr_address, BASE + 32'h18);
    check("jal2_v0", register_v0, 32'd32);
    clk_enable = 1'b0;
    step(5);
    check("freeze_pc", instr_address, BASE + 32'h18);
    check("freeze_v0", register_v0, 32'd32);
    clk_enable = 1'b1;
    run_to_halt(50);
    check("jal_final_v0", register_v0, 32'd44);
    check("jal_halt_active", {31'd0, active}, 32'd0);
    step(3);
    check("halt_hold_pc", instr_address, 32'h0);
    check("halt_hold_v0", register_v0, 32'd44);

    // Asynchronous reset between edges, then reset while a jump target is armed
    do_reset();
    step(4);
    check("pre_rst_v0", register_v0, 32'd32);
    #1 reset = 1'b1;
    #1;
    check("async_rst_pc", instr_address, BASE);
    check("async_rst_v0", register_v0, 32'd0);
    check("async_rst_active", {31'd0, active}, 32'd1);
    reset = 1'b0;
    step(3);
    check("armed_pc", instr_address, BASE + 32'h10);
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    step(1);
    check("rst_drops_target", instr_address, BASE + 32'h4);

    // ALU program
    clear_rom();
    rom[0]  = i_type(6'h0F, 5'd0, 5'd2, 16'h8000);      // lui $2,0x8000
    rom[1]  = r_type(5'd0, 5'd2, 5'd2, 5'd4, 6'h03);    // sra $2,$2,4
    rom[2]  = i_type(6'h0B, 5'd0, 5'd2, 16'd1);         // sltiu $2,$0,1
    rom[3]  = i_type(6'h09, 5'd0, 5'd5, 16'hFFFF);      // addiu $5,$0,-1
    rom[4]  = r_type(5'd0, 5'd5, 5'd2, 5'd28, 6'h02);   // srl $2,$5,28
    rom[5]  = r_type(5'd5, 5'd0, 5'd2, 5'd0, 6'h2A);    // slt $2,$5,$0
    rom[6]  = r_type(5'd5, 5'd0, 5'd2, 5'd0, 6'h2B);    // sltu $2,$5,$0
    rom[7]  = i_type(6'h0D, 5'd0, 5'd2, 16'hF0F0);      // ori $2,$0,0xF0F0
    rom[8]  = i_type(6'h0C, 5'd5, 5'd2, 16'h8001);      // andi $2,$5,0x8001
    rom[9]  = i_type(6'h0E, 5'd5, 5'd2, 16'h00FF);      // xori $2,$5,0x00FF
    rom[10] = r_type(5'd0, 5'd5, 5'd2, 5'd0, 6'h23);    // subu $2,$0,$5
    rom[11] = r_type(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);    // jr $0
    do_reset();
    step(2);
    check("sra_v0", register_v0, 32'hF8000000);
    step(1);
    check("sltiu_v0", register_v0, 32'd1);
    step(2);
    check("srl_v0", register_v0, 32'h0000000F);
    step(1);
    check("slt_v0", register_v0, 32'd1);
    step(1);
    check("sltu_v0", register_v0, 32'd0);
    step(1);
    check("ori_v0", register_v0, 32'h0000F0F0);
    step(1);
    check("andi_v0", register_v0, 32'h00008001);
    step(1);
    check("xori_v0", register_v0, 32'hFFFFFF00);
    step(1);
    check("subu_v0", register_v0, 32'd1);
    run_to_halt(20);
    check("alu_halt_active", {31'd0, active}, 32'd0);

    // Memory program
    clear_rom();
    rom[0] = i_type(6'h09, 5'd0, 5'd4, 16'h0055);   // addiu $4,$0,0x55
    rom[1] = i_type(6'h2B, 5'd0, 5'd4, 16'd8);      // sw $4,8($0)
    rom[2] = i_type(6'h23, 5'd0, 5'd2, 16'd8);      // lw $2,8($0)
    rom[3] = r_type(5'd0, 5'd0, 5'd0, 5'd0, 6'h08); // jr $0
    do_reset();
    check("mem_rst_dw", {31'd0, data_write}, 32'd0);
    step(1);
    clk_enable = 1'b0;
    #1;
    check("sw_frozen_dw", {31'd0, data_write}, 32'd0);
    clk_enable = 1'b1;
    #1;
    check("sw_dw", {31'd0, data_write}, 32'd1);
    check("sw_addr", data_address, 32'd8);
    check("sw_wdata", data_writedata, 32'h55);
    dw_count = 0;
    step(1);
    check("lw_dw", {31'd0, data_write}, 32'd0);
    check("lw_dr", {31'd0, data_read}, 32'd1);
    check("lw_rdata", data_readdata, 32'h55);
    step(1);
    check("lw_v0", register_v0, 32'h55);
    run_to_halt(20);
    check("halted_dr", {31'd0, data_read}, 32'd0);
    check("dw_cycles", dw_count, 32'd1);

    // Branch program
    clear_rom();
    rom[0]  = i_type(6'h05, 5'd0, 5'd0, 16'd5);       // bne $0,$0,+5 (not taken)
    rom[1]  = i_type(6'h09, 5'd2, 5'd2, 16'd3);       // addiu $2,$2,3
    rom[2]  = i_type(6'h04, 5'd0, 5'd0, 16'd2);       // beq $0,$0,+2
    rom[3]  = i_type(6'h09, 5'd0, 5'd2, 16'd7);       // addiu $2,$0,7 (delay slot)
    rom[4]  = i_type(6'h09, 5'd2, 5'd2, 16'd1);       // skipped
    rom[5]  = i_type(6'h07, 5'd2, 5'd0, 16'd2);       // bgtz $2,+2 (taken)
    rom[6]  = 32'h0;                                  // nop (delay slot)
    rom[7]  = i_type(6'h09, 5'd2, 5'd2, 16'd100);     // skipped
    rom[8]  = i_type(6'h01, 5'd2, 5'd0, 16'd2);       // bltz $2,+2 (not taken)
    rom[9]  = i_type(6'h09, 5'd2, 5'd2, 16'd1);       // addiu $2,$2,1
    rom[10] = r_type(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);  // jr $0
    do_reset();
    step(2);
    check("bne_fallthru_pc", instr_address, BASE + 32'h8);
    check("bne_v0", register_v0, 32'd3);
    step(2);
    check("beq_target_pc", instr_address, BASE + 32'h14);
    check("beq_delay_v0", register_v0, 32'd7);
    step(2);
    check("bgtz_target_pc", instr_address, BASE + 32'h20);
    run_to_halt(20);
    check("branch_final_v0", register_v0, 32'd8);
    check("branch_halt_active", {31'd0, active}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
